// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB requester: FSM state enum, default widths,
// default ACCESS-phase timeout and a counter-width helper.
package apb_pkg;

  localparam int unsigned ApbAddrWidth     = 8;
  localparam int unsigned ApbDataWidth     = 32;
  localparam int unsigned ApbTimeoutCycles = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Wait counter only has to reach cycles-1 before it fires.
  function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response stream plus APB bus seen by the requester (master modport) and by
// whatever drives commands and models the completer (slave modport).
interface apb_master_if #(
  parameter int unsigned ADDR_WIDTH = apb_pkg::ApbAddrWidth,
  parameter int unsigned DATA_WIDTH = apb_pkg::ApbDataWidth
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;

  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_master_tmo.sv
// ACCESS-phase wait counter: cleared while in SETUP, counts PREADY-low ACCESS cycles and
// flags expiry on the TIMEOUT_CYCLES-th such cycle.
module apb_master_tmo
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = ApbTimeoutCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic wait_i,
  output logic expired_o
);

  localparam int unsigned CntWidth = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TIMEOUT_CYCLES - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wait_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = wait_i && (cnt_q == LastCnt);

endmodule

// File: rtl/apb_master.sv
// APB requester: converts a valid/ready command stream into SETUP/ACCESS transfers and
// returns one response pulse per command. Define APB_MASTER_TIMEOUT_EN to bound ACCESS waits.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ApbAddrWidth,
  parameter int unsigned DATA_WIDTH     = ApbDataWidth,
  parameter int unsigned TIMEOUT_CYCLES = ApbTimeoutCycles
) (
  input logic        PCLK,
  input logic        PRESET,
  apb_master_if.master bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_tmo_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_e state_q, state_d;

  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

  logic req_ready;
  logic psel;
  logic penable;
  logic accept;
  logic tmo_expired;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_tmo #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .clr_i    (state_q == SETUP),
    .wait_i   ((state_q == ACCESS) && !bus.PREADY),
    .expired_o(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  assign accept = bus.req_valid && req_ready;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    if (accept) begin
      write_d = bus.req_write;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? '0 : bus.PRDATA;
          rsp_error_d = bus.PSLVERR;
          // A command taken in the completing cycle skips IDLE entirely.
          state_d     = bus.req_valid ? SETUP : IDLE;
        end else if (tmo_expired) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    unique case (state_q)
      IDLE:   req_ready = 1'b1;
      SETUP:  psel      = 1'b1;
      ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        req_ready = bus.PREADY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.PSELx     = psel;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = write_q;
  assign bus.PADDR     = addr_q;
  assign bus.PWDATA    = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

endmodule
